// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
// branch_predictor: 2-bit BTB predictor and misprediction controller.
//   Fetch side : PC_curr -> predicted_taken / predicted_target (combinational lookup)
//   Decode side: update_en, IF_ID_* prediction info, Branch, actual_taken/target
//                -> mispredicted / PC_correct (combinational), table update at clk edge
//   Stats      : branch_count / mispredict_count (registered, saturating)
module branch_predictor #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] PC_curr,
   output logic        predicted_taken,
   output logic [15:0] predicted_target,
   input  logic        update_en,
   input  logic [15:0] IF_ID_PC_curr,
   input  logic [15:0] IF_ID_PC_next,
   input  logic        IF_ID_predicted_taken,
   input  logic [15:0] IF_ID_predicted_target,
   input  logic        Branch,
   input  logic        actual_taken,
   input  logic [15:0] actual_target,
   output logic        mispredicted,
   output logic [15:0] PC_correct,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   localparam int unsigned TAG_W   = 15 - IDX_W;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // BTB storage
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [15:0]      target_q [ENTRIES];
   logic [1:0]       cnt_q    [ENTRIES];

   logic [15:0] branch_count_q, branch_count_d;
   logic [15:0] mispredict_count_q, mispredict_count_d;

   // Instruction PCs are halfword aligned; bit 0 carries no index/tag information
   logic unused_pc_lsb;
   assign unused_pc_lsb = PC_curr[0] ^ IF_ID_PC_curr[0];

   // Fetch lookup
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   assign f_idx = PC_curr[IDX_W:1];
   assign f_tag = PC_curr[15:IDX_W+1];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   assign predicted_taken  = f_hit & cnt_q[f_idx][1];
   assign predicted_target = predicted_taken ? target_q[f_idx] : 16'h0000;

   // Resolution: flush decision and redirect PC
   always_comb begin
      mispredicted = 1'b0;
      PC_correct   = 16'h0000;
      if (update_en) begin
         if (Branch) begin
            mispredicted = (actual_taken != IF_ID_predicted_taken) |
                           (actual_taken & IF_ID_predicted_taken &
                            (actual_target != IF_ID_predicted_target));
         end else begin
            mispredicted = IF_ID_predicted_taken;
         end
         if (mispredicted) begin
            PC_correct = (Branch && actual_taken) ? actual_target : IF_ID_PC_next;
         end
      end
   end

   // Decode-side entry lookup for training
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   assign u_idx = IF_ID_PC_curr[IDX_W:1];
   assign u_tag = IF_ID_PC_curr[15:IDX_W+1];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   // Next contents of the single entry written this cycle
   logic             wr_en;
   logic             wr_valid;
   logic [TAG_W-1:0] wr_tag;
   logic [15:0]      wr_target;
   logic [1:0]       wr_cnt;

   always_comb begin
      wr_en     = 1'b0;
      wr_valid  = valid_q[u_idx];
      wr_tag    = tag_q[u_idx];
      wr_target = target_q[u_idx];
      wr_cnt    = cnt_q[u_idx];
      if (update_en) begin
         if (Branch) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_tag   = u_tag;
            if (!u_hit) begin
               // Allocate (overwrites any aliasing entry), weakly biased toward outcome
               wr_target = actual_target;
               wr_cnt    = actual_taken ? 2'b10 : 2'b01;
            end else if (actual_taken) begin
               // Target refresh tracks BR whose register target changes
               wr_target = actual_target;
               if (cnt_q[u_idx] != 2'b11) wr_cnt = cnt_q[u_idx] + 2'd1;
            end else if (cnt_q[u_idx] != 2'b00) begin
               wr_cnt = cnt_q[u_idx] - 2'd1;
            end
         end else if (IF_ID_predicted_taken && u_hit) begin
            // False hit on a non-branch: drop the entry
            wr_en    = 1'b1;
            wr_valid = 1'b0;
         end
      end
   end

   // Table state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 16'h0000;
            cnt_q[i]    <= 2'b01;
         end
      end else if (wr_en) begin
         valid_q[u_idx]  <= wr_valid;
         tag_q[u_idx]    <= wr_tag;
         target_q[u_idx] <= wr_target;
         cnt_q[u_idx]    <= wr_cnt;
      end
   end

   // Saturating statistics
   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (update_en && Branch && (branch_count_q != CNT_MAX)) begin
         branch_count_d = branch_count_q + 16'd1;
      end
      if (mispredicted && (mispredict_count_q != CNT_MAX)) begin
         mispredict_count_d = mispredict_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count_q     <= 16'h0000;
         mispredict_count_q <= 16'h0000;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
// tb_branch_predictor: directed scenarios plus random traffic, checked every
// cycle against a behavioural BTB model held in integer arrays.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] PC_curr = '0;
   logic        predicted_taken;
   logic [15:0] predicted_target;
   logic        update_en = 1'b0;
   logic [15:0] IF_ID_PC_curr = '0;
   logic [15:0] IF_ID_PC_next = '0;
   logic        IF_ID_predicted_taken = 1'b0;
   logic [15:0] IF_ID_predicted_target = '0;
   logic        Branch = 1'b0;
   logic        actual_taken = 1'b0;
   logic [15:0] actual_target = '0;
   logic        mispredicted;
   logic [15:0] PC_correct;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .PC_curr(PC_curr),
      .predicted_taken(predicted_taken), .predicted_target(predicted_target),
      .update_en(update_en), .IF_ID_PC_curr(IF_ID_PC_curr), .IF_ID_PC_next(IF_ID_PC_next),
      .IF_ID_predicted_taken(IF_ID_predicted_taken), .IF_ID_predicted_target(IF_ID_predicted_target),
      .Branch(Branch), .actual_taken(actual_taken), .actual_target(actual_target),
      .mispredicted(mispredicted), .PC_correct(PC_correct),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: a table keyed by PC/2 mod 8, tag = PC/16
   bit m_valid [8];
   int m_tag   [8];
   int m_tgt   [8];
   int m_cnt   [8];
   int m_bc, m_mc;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      m_bc = 0; m_mc = 0;
   endfunction

   function automatic int ix(input int pc); return (pc / 2) % 8; endfunction

   function automatic bit m_hit(input int pc);
      return m_valid[ix(pc)] && (m_tag[ix(pc)] == pc / 16);
   endfunction

   function automatic bit m_pred(input int pc);
      return m_hit(pc) && (m_cnt[ix(pc)] >= 2);
   endfunction

   function automatic bit m_mis();
      if (!update_en) return 1'b0;
      if (Branch)
         return (actual_taken != IF_ID_predicted_taken) ||
                (actual_taken && IF_ID_predicted_taken && actual_target != IF_ID_predicted_target);
      return IF_ID_predicted_taken;
   endfunction

   function automatic int m_pcc();
      if (!m_mis()) return 0;
      return (Branch && actual_taken) ? int'(actual_target) : int'(IF_ID_PC_next);
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge rst_n) model_reset();

   // Model training on the same edge the DUT writes
   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else if (update_en) begin
         int i, pc;
         pc = int'(IF_ID_PC_curr);
         i  = ix(pc);
         if (m_mis()) m_mc = (m_mc < 65535) ? m_mc + 1 : m_mc;
         if (Branch) begin
            m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
            if (!m_hit(pc)) begin
               m_valid[i] = 1'b1; m_tag[i] = pc / 16;
               m_tgt[i] = int'(actual_target); m_cnt[i] = actual_taken ? 2 : 1;
            end else if (actual_taken) begin
               m_tgt[i] = int'(actual_target);
               m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            end else begin
               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
         end else if (IF_ID_predicted_taken && m_hit(pc)) begin
            m_valid[i] = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         bit p;
         p = m_pred(int'(PC_curr));
         check("predicted_taken", 16'(predicted_taken), 16'(p));
         check("predicted_target", predicted_target, p ? 16'(m_tgt[ix(int'(PC_curr))]) : 16'h0000);
         check("mispredicted", 16'(mispredicted), 16'(m_mis()));
         check("PC_correct", PC_correct, 16'(m_pcc()));
         check("branch_count", branch_count, 16'(m_bc));
         check("mispredict_count", mispredict_count, 16'(m_mc));
      end
   end

   task automatic resolve(input bit en, input bit br, input logic [15:0] pc, input bit ipt,
                          input logic [15:0] itgt, input bit at, input logic [15:0] atgt);
      update_en = en; Branch = br; IF_ID_PC_curr = pc; IF_ID_PC_next = pc + 16'd2;
      IF_ID_predicted_taken = ipt; IF_ID_predicted_target = itgt;
      actual_taken = at; actual_target = atgt;
   endtask

   task automatic idle(); resolve(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0); endtask

   // Settle, sample mid-cycle, then advance to just after the next edge
   task automatic look(); @(negedge clk); #1; endtask
   task automatic next(); @(posedge clk); #1; endtask

   logic [15:0] pc_pool  [8] = '{16'h0010, 16'h0110, 16'h0022, 16'h0122,
                                 16'h0034, 16'h003C, 16'h013C, 16'h000E};
   logic [15:0] tgt_pool [4] = '{16'h0040, 16'h0080, 16'h0200, 16'h0300};

   initial begin
      model_reset();
      idle();
      PC_curr = 16'h0010;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      look();
      check("reset_pt", 16'(predicted_taken), 16'h0);
      check("reset_tgt", predicted_target, 16'h0000);
      check("reset_bc", branch_count, 16'h0);
      check("reset_mc", mispredict_count, 16'h0);
      next();

      // Cold branch at 0x10, taken to 0x40
      resolve(1, 1, 16'h0010, 0, 16'h0, 1, 16'h0040);
      look();
      check("cold_mis", 16'(mispredicted), 16'h1);
      check("cold_pcc", PC_correct, 16'h0040);
      check("cold_pt_before", 16'(predicted_taken), 16'h0);
      next(); idle(); look();
      check("cold_pt_after", 16'(predicted_taken), 16'h1);
      check("cold_tgt_after", predicted_target, 16'h0040);
      check("cold_bc", branch_count, 16'h1);
      check("cold_mc", mispredict_count, 16'h1);
      next();

      // Three more taken -> strongly taken
      repeat (3) begin
         resolve(1, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040);
         look(); check("taken_nomis", 16'(mispredicted), 16'h0); next();
      end
      resolve(1, 1, 16'h0010, 1, 16'h0040, 0, 16'h0040);
      look();
      check("nt1_mis", 16'(mispredicted), 16'h1);
      check("nt1_pcc", PC_correct, 16'h0012);
      next(); idle(); look();
      check("nt1_still_taken", 16'(predicted_taken), 16'h1);
      next();
      resolve(1, 1, 16'h0010, 1, 16'h0040, 0, 16'h0040);
      next(); idle(); look();
      check("nt2_not_taken", 16'(predicted_taken), 16'h0);
      next();

      // Retrain, then BR target change
      resolve(1, 1, 16'h0010, 0, 16'h0, 1, 16'h0040);
      next(); idle(); look();
      check("retrain_pt", 16'(predicted_taken), 16'h1);
      next();
      resolve(1, 1, 16'h0010, 1, 16'h0040, 1, 16'h0080);
      look();
      check("br_mis", 16'(mispredicted), 16'h1);
      check("br_pcc", PC_correct, 16'h0080);
      next(); idle(); look();
      check("br_new_tgt", predicted_target, 16'h0080);
      next();

      // Alias at 0x110 evicts 0x10
      resolve(1, 1, 16'h0110, 0, 16'h0, 1, 16'h0200);
      next(); idle(); look();
      check("alias_old_miss", 16'(predicted_taken), 16'h0);
      next();
      PC_curr = 16'h0110; look();
      check("alias_new_tgt", predicted_target, 16'h0200);
      next();

      // False hit on a non-branch
      resolve(1, 0, 16'h0110, 1, 16'h0200, 1, 16'h0300);
      look();
      check("nonbr_mis", 16'(mispredicted), 16'h1);
      check("nonbr_pcc", PC_correct, 16'h0112);
      next(); idle(); look();
      check("nonbr_invalidated", 16'(predicted_taken), 16'h0);
      next();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] pc;
         bit ipt;
         pc = pc_pool[$urandom_range(0, 7)];
         ipt = ($urandom_range(0, 1) == 0) ? m_pred(int'(pc)) : 1'($urandom_range(0, 1));
         resolve(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), pc, ipt,
                 (ipt && m_hit(int'(pc))) ? 16'(m_tgt[ix(int'(pc))]) : tgt_pool[$urandom_range(0, 3)],
                 1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)]);
         PC_curr = pc_pool[$urandom_range(0, 7)];
         next();
      end

      // Train 0x10 strongly, then async reset between edges
      repeat (3) begin
         resolve(1, 1, 16'h0010, m_pred(16'h0010), 16'(m_tgt[ix(16'h0010)]), 1, 16'h0040);
         next();
      end
      idle(); PC_curr = 16'h0010; look();
      check("pre_reset_pt", 16'(predicted_taken), 16'h1);
      next();
      #2 rst_n = 1'b0;
      #1;
      check("async_pt", 16'(predicted_taken), 16'h0);
      check("async_bc", branch_count, 16'h0);
      check("async_mc", mispredict_count, 16'h0);
      next();
      #1 rst_n = 1'b1;
      next();

      // Mispredict counter saturation
      resolve(1, 0, 16'h0022, 1, 16'h0040, 0, 16'h0);
      repeat (65535) @(posedge clk);
      #1;
      check("mc_at_max", mispredict_count, 16'hFFFF);
      next();
      check("mc_saturated", mispredict_count, 16'hFFFF);
      idle();
      next();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
